// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer for the 8-bit accumulator
// processor. Sole master of storeRAM (registered read, 1-cycle latency).
// Holds PC, IR and accumulator A; IN operands arrive over a valid/ready port.
// Optional feature: define STEP_MODE_EN to add the `step` port and a
// STEP_WAIT state that gates every FETCH except the first after Start.
module cpu_control_unit #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ram_init,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ir,
`ifdef STEP_MODE_EN
    output logic          halted,
    input  logic          step
`else
    output logic          halted
`endif
);

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_WB,
        S_EXEC_WR,
        S_IN_WAIT,
        S_HALT,
        S_STEP_WAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

`ifdef STEP_MODE_EN
    localparam state_t NEXT_FETCH = S_STEP_WAIT;
`else
    localparam state_t NEXT_FETCH = S_FETCH;
`endif

    state_t        state, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] pc_inc;
    op_t           dec_op;
    op_t           ex_op;
    logic          a_zero;
    logic          a_pos;

    assign pc_inc    = pc_q + AW'(1);
    assign dec_op    = op_t'(ram_rdata[DW-1 -: 3]);
    assign ex_op     = op_t'(ir_q[DW-1 -: 3]);
    assign a_zero    = (a_q == '0);
    assign a_pos     = !a_q[DW-1] && !a_zero;
    assign ram_wdata = a_q;
    assign acc       = a_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

    // State and datapath registers; synchronous reset beats everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_INIT;
            a_q   <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
        end else begin
            state <= state_d;
            a_q   <= a_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
        end
    end

    // Next-state, datapath updates and RAM/handshake controls.
    always_comb begin
        state_d  = state;
        a_d      = a_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ram_init = 1'b0;
        ram_we   = 1'b0;
        ram_addr = pc_q;
        in_ready = 1'b0;
        halted   = 1'b0;
        case (state)
            S_INIT: begin
                ram_init = 1'b1;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    a_d     = '0;
                end
            end
            S_FETCH: begin
                ram_addr = pc_q;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d = ram_rdata;
                case (dec_op)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        pc_d    = pc_inc;
                        state_d = S_EXEC_RD;
                    end
                    OP_STORE: begin
                        pc_d    = pc_inc;
                        state_d = S_EXEC_WR;
                    end
                    OP_IN: begin
                        pc_d    = pc_inc;
                        state_d = S_IN_WAIT;
                    end
                    OP_JZ: begin
                        pc_d    = a_zero ? ram_rdata[AW-1:0] : pc_inc;
                        state_d = NEXT_FETCH;
                    end
                    OP_JPOS: begin
                        pc_d    = a_pos ? ram_rdata[AW-1:0] : pc_inc;
                        state_d = NEXT_FETCH;
                    end
                    default: begin
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EXEC_RD: begin
                ram_addr = ir_q[AW-1:0];
                state_d  = S_EXEC_WB;
            end
            S_EXEC_WB: begin
                case (ex_op)
                    OP_LOAD: a_d = ram_rdata;
                    OP_ADD:  a_d = a_q + ram_rdata;
                    OP_SUB:  a_d = a_q - ram_rdata;
                    default: a_d = a_q;
                endcase
                state_d = NEXT_FETCH;
            end
            S_EXEC_WR: begin
                ram_addr = ir_q[AW-1:0];
                ram_we   = 1'b1;
                state_d  = NEXT_FETCH;
            end
            S_IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = NEXT_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (Start) state_d = S_INIT;
            end
`ifdef STEP_MODE_EN
            S_STEP_WAIT: begin
                if (step) state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_INIT;
            end
        endcase
        // Reset is synchronous for state, but the RAM strobes are masked
        // combinationally so a Reset raised mid-STORE never lands a write and
        // the INIT pulse after reset is exactly one cycle wide.
        if (Reset) begin
            ram_we   = 1'b0;
            ram_init = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed test of cpu_control_unit running a GCD
// program from a behavioural storeRAM model. Build with STEP_MODE_EN to
// exercise single-step operation as well.
module tb_cpu_control_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ram_init;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] acc;
    logic [4:0] pc;
    logic [7:0] ir;
    logic       halted;
    logic       step;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [7:0] mem [32];

    cpu_control_unit #(.AW(5), .DW(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_init (ram_init),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .acc      (acc),
        .pc       (pc),
        .ir       (ir),
`ifdef STEP_MODE_EN
        .halted   (halted),
        .step     (step)
`else
        .halted   (halted)
`endif
    );

    always #5 Clock = ~Clock;

    // GCD image: M[30]=x, M[31]=y, subtract smaller from larger until equal.
    function automatic logic [7:0] image(input int unsigned a);
        case (a)
            0:  return 8'h80; // IN
            1:  return 8'h3E; // STORE 30
            2:  return 8'h80; // IN
            3:  return 8'h3F; // STORE 31
            4:  return 8'h1E; // LOAD 30
            5:  return 8'h7F; // SUB 31
            6:  return 8'hAF; // JZ 15
            7:  return 8'hCC; // JPOS 12
            8:  return 8'h1F; // LOAD 31
            9:  return 8'h7E; // SUB 30
            10: return 8'h3F; // STORE 31
            11: return 8'hC4; // JPOS 4
            12: return 8'h3E; // STORE 30
            13: return 8'hC4; // JPOS 4
            14: return 8'hE0; // HALT
            15: return 8'h1E; // LOAD 30
            16: return 8'hE0; // HALT
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural storeRAM: registered read, Initialize reloads the image.
    always @(posedge Clock) begin
        if (ram_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= image(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_run();
        Start = 1'b1;
        repeat (3) tick();
        Start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] val);
        int unsigned n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = val;
        tick();
        in_valid = 1'b0;
        check("in_acc", acc, val);
    endtask

    task automatic wait_halt();
        int unsigned n = 0;
        while (!halted && n < 500) begin
            tick();
            n++;
        end
        check("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step     = 1'b1;

        // Reset, then exactly one INIT cycle.
        tick();
        check("init_masked_in_reset", {31'd0, ram_init}, 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        check("init_pulse", {31'd0, ram_init}, 32'd1);
        check("rst_acc", acc, 8'd0);
        check("rst_pc", pc, 5'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        tick();
        check("init_one_cycle", {31'd0, ram_init}, 32'd0);
        check("idle_halted", {31'd0, halted}, 32'd0);

        // GCD(12,8) with an input stall on the first IN.
        start_run();
        begin
            int unsigned n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        check("stall_pc", pc, 5'd1);
        check("stall_acc", acc, 8'd0);
        feed(8'd12);
        feed(8'd8);
        wait_halt();
        check("gcd_acc", acc, 8'd4);
        check("gcd_pc", pc, 5'd16);
        check("gcd_m30", mem[30], 8'd4);
        check("gcd_m31", mem[31], 8'd4);
        repeat (3) tick();
        check("halt_frozen_acc", acc, 8'd4);
        check("halt_frozen_pc", pc, 5'd16);

        // Re-run from HALT with equal operands: JZ at PC 6 is taken.
        start_run();
        feed(8'd5);
        feed(8'd5);
        wait_halt();
        check("eq_acc", acc, 8'd5);
        check("eq_pc", pc, 5'd16);
        check("eq_m31", mem[31], 8'd5);

        // Reset raised during the first STORE's write cycle.
        start_run();
        feed(8'd12);
        begin
            int unsigned n = 0;
            while (!ram_we && n < 20) begin
                tick();
                n++;
            end
        end
        check("we_seen", {31'd0, ram_we}, 32'd1);
        Reset = 1'b1;
        #1;
        check("we_masked", {31'd0, ram_we}, 32'd0);
        tick();
        check("no_write_m30", mem[30], 8'd0);
        Reset = 1'b0;
        #1;
        check("midrst_acc", acc, 8'd0);
        check("midrst_pc", pc, 5'd0);
        check("midrst_init", {31'd0, ram_init}, 32'd1);
        tick();

`ifdef STEP_MODE_EN
        // Single step: three pulses run exactly three instructions.
        step = 1'b0;
        start_run();
        feed(8'd7);
        repeat (5) tick();
        check("step_hold_pc", pc, 5'd1);
        check("step_hold_acc", acc, 8'd7);
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        check("step1_pc", pc, 5'd2);
        step = 1'b1; tick(); step = 1'b0;
        feed(8'd9);
        check("step2_pc", pc, 5'd3);
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        repeat (5) tick();
        check("step3_pc", pc, 5'd4);
        check("step3_acc", acc, 8'd9);
        check("step3_m31", mem[31], 8'd9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
